// File: rtl/nios_system_multi_timer_pkg.sv
// Shared constants for the multi-channel interval timer: per-channel register
// offsets, CONTROL/STATUS bit positions and a half-word select helper.
package nios_system_multi_timer_pkg;

  // Per-channel register offsets (address[2:0])
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // CONTROL bit indices
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // STATUS bit indices
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Select the low or high 16-bit half of a zero-extended 32-bit word
  function automatic logic [15:0] half_word(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/nios_system_multi_timer_chan.sv
// One timer channel: down-counter, period, TO/RUN/ITO/CONT state and, when
// MULTI_TIMER_SNAPSHOT_EN is defined, a software-triggered counter snapshot.
// The read word is combinational; the top level registers it.
module nios_system_multi_timer_chan
  import nios_system_multi_timer_pkg::*;
#(
  parameter int               CNT_W          = 20,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = '1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  offset,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  logic             to_q, to_d;
  logic             run_q, run_d;
  logic             ito_q, ito_d;
  logic             cont_q, cont_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout;
  logic [31:0]      period_ext;
`ifdef MULTI_TIMER_SNAPSHOT_EN
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [31:0]      snap_ext;
  assign snap_ext = 32'(snap_q);
`endif

  assign timeout    = run_q && (count_q == '0);
  assign period_ext = 32'(period_q);
  assign irq        = to_q & ito_q;

  // Next state: counting first, then software writes layered on top; a
  // timeout on the same edge as a STATUS write keeps TO set.
  always_comb begin
    // NOTE: every _d is given its hold value first so no path infers a latch.
    to_d     = to_q | timeout;
    run_d    = run_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    load_d   = 1'b0;
    period_d = period_q;
    count_d  = count_q;
`ifdef MULTI_TIMER_SNAPSHOT_EN
    snap_d   = snap_q;
`endif
    if (load_q)      count_d = period_q;
    else if (run_q)  count_d = timeout ? period_q : count_q - CNT_W'(1);
    if (timeout && !cont_q) run_d = 1'b0;

    if (wr_en) begin
      case (offset)
        REG_STATUS:  if (!timeout) to_d = 1'b0;
        REG_CONTROL: begin
          ito_d  = wdata[CTRL_ITO];
          cont_d = wdata[CTRL_CONT];
          if (wdata[CTRL_STOP])       run_d = 1'b0;
          else if (wdata[CTRL_START]) run_d = 1'b1;
        end
        REG_PERIODL: begin
          period_d = CNT_W'({period_ext[31:16], wdata});
          run_d    = 1'b0;
          load_d   = 1'b1;
        end
        REG_PERIODH: begin
          period_d = CNT_W'({wdata, period_ext[15:0]});
          run_d    = 1'b0;
          load_d   = 1'b1;
        end
`ifdef MULTI_TIMER_SNAPSHOT_EN
        REG_SNAPL, REG_SNAPH: snap_d = count_q;
`endif
        default: ;
      endcase
    end
  end

  // Read word for the currently addressed offset
  always_comb begin
    rdata = '0;
    case (offset)
      REG_STATUS: begin
        rdata[STAT_TO]  = to_q;
        rdata[STAT_RUN] = run_q;
      end
      REG_CONTROL: begin
        rdata[CTRL_ITO]  = ito_q;
        rdata[CTRL_CONT] = cont_q;
      end
      REG_PERIODL: rdata = half_word(period_ext, 1'b0);
      REG_PERIODH: rdata = half_word(period_ext, 1'b1);
`ifdef MULTI_TIMER_SNAPSHOT_EN
      REG_SNAPL:   rdata = half_word(snap_ext, 1'b0);
      REG_SNAPH:   rdata = half_word(snap_ext, 1'b1);
`endif
      default: ;
    endcase
  end

  // Channel state registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    if (reset) begin
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      load_q   <= 1'b0;
      period_q <= DEFAULT_PERIOD;
      count_q  <= DEFAULT_PERIOD;
`ifdef MULTI_TIMER_SNAPSHOT_EN
      snap_q   <= '0;
`endif
    end else begin
      to_q     <= to_d;
      run_q    <= run_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      load_q   <= load_d;
      period_q <= period_d;
      count_q  <= count_d;
`ifdef MULTI_TIMER_SNAPSHOT_EN
      snap_q   <= snap_d;
`endif
    end
  end

endmodule

// File: rtl/nios_system_multi_timer.sv
// Multi-channel interval timer, Avalon-MM slave. Decodes address into channel
// and register offset, registers the read mux and ORs the channel interrupts.
// Optional feature macro: MULTI_TIMER_SNAPSHOT_EN (counter snapshot registers).
module nios_system_multi_timer
  import nios_system_multi_timer_pkg::*;
#(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_W          = 20,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h000F_423F,
  parameter int          ADDR_W         = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] ch_irq
);

  localparam int SEL_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;

  logic [SEL_W-1:0]  ch_sel;
  logic              wr;
  logic [NUM_CH-1:0] ch_wr;
  logic [15:0]       ch_rdata [NUM_CH];
  logic [15:0]       readdata_d, readdata_q;

  generate
    if (ADDR_W > 3) begin : g_sel
      assign ch_sel = address[ADDR_W-1:3];
    end else begin : g_sel_single
      assign ch_sel = '0;
    end
  endgenerate

  assign wr = chipselect & ~write_n;

  // Channel decode: write enables and read mux; out-of-range channels match nothing
  always_comb begin
    ch_wr      = '0;
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(ch_sel) == i) begin
        ch_wr[i]   = wr;
        readdata_d = ch_rdata[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      nios_system_multi_timer_chan #(
        .CNT_W         (CNT_W),
        .DEFAULT_PERIOD(DEFAULT_PERIOD[CNT_W-1:0])
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .wr_en (ch_wr[g]),
        .offset(address[2:0]),
        .wdata (writedata),
        .rdata (ch_rdata[g]),
        .irq   (ch_irq[g])
      );
    end
  endgenerate

  // Registered read data: one cycle of read latency
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |ch_irq;

endmodule

// File: tb/tb_nios_system_multi_timer.sv
// Self-checking bench for nios_system_multi_timer (3 channels, 20-bit counters).
// Every cycle is compared against a behavioural model; table-driven register
// vectors and hand-written timing sequences add constant expectations.
module tb_nios_system_multi_timer;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 20;
  localparam int ADDR_W = 5;
  localparam int unsigned DEF_P = 32'h000F_423F;
`ifdef MULTI_TIMER_SNAPSHOT_EN
  localparam bit SNAP_ON = 1'b1;
`else
  localparam bit SNAP_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] ch_irq;

  always #5 clk = ~clk;

  nios_system_multi_timer #(
    .NUM_CH        (NUM_CH),
    .CNT_W         (CNT_W),
    .DEFAULT_PERIOD(32'h000F_423F)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .ch_irq    (ch_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state, one entry per channel
  int unsigned m_per  [NUM_CH];
  int unsigned m_cnt  [NUM_CH];
  int unsigned m_snap [NUM_CH];
  bit          m_to   [NUM_CH];
  bit          m_run  [NUM_CH];
  bit          m_ito  [NUM_CH];
  bit          m_cont [NUM_CH];
  bit          m_load [NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_per[c] = DEF_P; m_cnt[c] = DEF_P; m_snap[c] = 0;
      m_to[c] = 0; m_run[c] = 0; m_ito[c] = 0; m_cont[c] = 0; m_load[c] = 0;
    end
  endfunction

  function automatic logic [15:0] model_read(input logic [ADDR_W-1:0] a);
    int ch  = int'(a) >> 3;
    int off = int'(a) & 7;
    if (ch >= NUM_CH) return 16'h0;
    case (off)
      0: return {14'd0, m_run[ch], m_to[ch]};
      1: return {14'd0, m_cont[ch], m_ito[ch]};
      2: return 16'(m_per[ch]);
      3: return 16'(m_per[ch] >> 16);
      4: return SNAP_ON ? 16'(m_snap[ch]) : 16'h0;
      5: return SNAP_ON ? 16'(m_snap[ch] >> 16) : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] model_irq();
    logic [NUM_CH-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_to[c] & m_ito[c];
    return v;
  endfunction

  // Advance the model by one clock edge given the bus write on that cycle
  function automatic void model_step(input bit wr, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    int wch = int'(a) >> 3;
    int off = int'(a) & 7;
    for (int c = 0; c < NUM_CH; c++) begin
      bit          fire    = m_run[c] && (m_cnt[c] == 0);
      int unsigned old_cnt = m_cnt[c];
      bit          hit     = wr && (wch == c);
      if (m_load[c] || fire) m_cnt[c] = m_per[c];
      else if (m_run[c])     m_cnt[c] = m_cnt[c] - 1;
      m_load[c] = 0;
      if (fire) begin
        m_to[c] = 1;
        if (!m_cont[c]) m_run[c] = 0;
      end
      if (hit) begin
        case (off)
          0: if (!fire) m_to[c] = 0;
          1: begin
            m_ito[c]  = d[0];
            m_cont[c] = d[1];
            if (d[3])      m_run[c] = 0;
            else if (d[2]) m_run[c] = 1;
          end
          2: begin
            m_per[c] = (m_per[c] & 32'hFFFF_0000) | 32'(d);
            m_run[c] = 0; m_load[c] = 1;
          end
          3: begin
            m_per[c] = (m_per[c] & 32'h0000_FFFF) | ((32'(d) % (1 << (CNT_W - 16))) << 16);
            m_run[c] = 0; m_load[c] = 1;
          end
          4, 5: if (SNAP_ON) m_snap[c] = old_cnt;
          default: ;
        endcase
      end
    end
  endfunction

  // One bus cycle: drive at negedge, model at posedge, compare at next negedge
  task automatic tick(input bit cs, input bit we, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    logic [15:0]       exp_rd;
    logic [NUM_CH-1:0] exp_ch;
    chipselect = cs; write_n = !we; address = a; writedata = d;
    exp_rd = model_read(a);
    @(posedge clk);
    model_step(cs && we, a, d);
    @(negedge clk);
    exp_ch = model_irq();
    check("readdata", {16'd0, readdata}, {16'd0, exp_rd});
    check("ch_irq", 32'(ch_irq), 32'(exp_ch));
    check("irq", 32'(irq), 32'(|exp_ch));
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    tick(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    tick(1'b1, 1'b0, a, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check("rst_readdata", 32'(readdata), 32'h0);
    check("rst_ch_irq", 32'(ch_irq), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
  endtask

  typedef struct {
    string             name;
    bit                we;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       wdata;
    logic [ADDR_W-1:0] raddr;
    logic [15:0]       exp;
  } vec_t;

  vec_t vecs [17];

  // Watchdog: the run must finish by itself
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          rises [$];
    int          n0, n1, found;
    logic        prev;
    logic [NUM_CH-1:0] prev_ch;

    vecs[0]  = '{"rst_st0",   0, 5'd0,  16'h0,    5'd0,  16'h0000};
    vecs[1]  = '{"rst_ct0",   0, 5'd0,  16'h0,    5'd1,  16'h0000};
    vecs[2]  = '{"rst_st1",   0, 5'd0,  16'h0,    5'd8,  16'h0000};
    vecs[3]  = '{"rst_ct1",   0, 5'd0,  16'h0,    5'd9,  16'h0000};
    vecs[4]  = '{"rst_st2",   0, 5'd0,  16'h0,    5'd16, 16'h0000};
    vecs[5]  = '{"rst_ct2",   0, 5'd0,  16'h0,    5'd17, 16'h0000};
    vecs[6]  = '{"rst_perl0", 0, 5'd0,  16'h0,    5'd2,  16'h423F};
    vecs[7]  = '{"rst_perh0", 0, 5'd0,  16'h0,    5'd3,  16'h000F};
    vecs[8]  = '{"rst_perl1", 0, 5'd0,  16'h0,    5'd10, 16'h423F};
    vecs[9]  = '{"oor_perl",  0, 5'd0,  16'h0,    5'd26, 16'h0000};
    vecs[10] = '{"perh_mask", 1, 5'd3,  16'hFFF5, 5'd3,  16'h0005};
    vecs[11] = '{"ctl_stopw", 1, 5'd1,  16'h000F, 5'd1,  16'h0003};
    vecs[12] = '{"st_idle",   0, 5'd0,  16'h0,    5'd0,  16'h0000};
    vecs[13] = '{"off6",      1, 5'd6,  16'hFFFF, 5'd6,  16'h0000};
    vecs[14] = '{"oor_write", 1, 5'd26, 16'h1234, 5'd18, 16'h423F};
    vecs[15] = '{"perl2",     1, 5'd18, 16'h0001, 5'd18, 16'h0001};
    vecs[16] = '{"start_run", 1, 5'd1,  16'h0006, 5'd0,  16'h0002};

    do_reset();

    // Register access table
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr);
      check(vecs[i].name, 32'(readdata), 32'(vecs[i].exp));
    end

    // Continuous mode, period 9: timeouts 10 and 20 edges after START
    do_reset();
    wr(5'd2, 16'd9); wr(5'd3, 16'd0); wr(5'd1, 16'h7);
    prev = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 11) wr(5'd0, 16'h0);
      else         rd(5'd0);
      if (irq && !prev) rises.push_back(k);
      prev = irq;
      if (k == 11) check("cont_clear", 32'(irq), 32'h0);
    end
    check("cont_nrises", 32'(rises.size()), 32'd2);
    check("cont_first", rises.size() > 0 ? 32'(rises[0]) : 32'hFFFF, 32'd10);
    check("cont_second", rises.size() > 1 ? 32'(rises[1]) : 32'hFFFF, 32'd20);
    check("cont_run", 32'(readdata), 32'h3);

    // One-shot mode on channel 1, period 4
    do_reset();
    wr(5'd10, 16'd4); wr(5'd11, 16'd0); wr(5'd9, 16'h5);
    rises.delete();
    prev = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      rd(5'd8);
      if (ch_irq[1] && !prev) rises.push_back(k);
      prev = ch_irq[1];
    end
    check("oneshot_nrises", 32'(rises.size()), 32'd1);
    check("oneshot_first", rises.size() > 0 ? 32'(rises[0]) : 32'hFFFF, 32'd5);
    check("oneshot_status", 32'(readdata), 32'h1);
    wr(5'd12, 16'h0);
    rd(5'd12);
    check("oneshot_hold", 32'(readdata), SNAP_ON ? 32'd4 : 32'd0);

    // STATUS write colliding with a timeout, then START|STOP
    do_reset();
    wr(5'd2, 16'd9); wr(5'd3, 16'd0); wr(5'd1, 16'h7);
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      if (m_run[0] && m_cnt[0] == 0) found = 1;
      else rd(5'd0);
    end
    check("collide_found", 32'(found), 32'd1);
    wr(5'd0, 16'h0);
    check("collide_to", 32'(ch_irq[0]), 32'h1);
    wr(5'd1, 16'hC);
    rd(5'd0);
    check("startstop", 32'(readdata), 32'h1);

    // Channel independence: ch1 period 3, ch0 period 7, both continuous
    do_reset();
    wr(5'd10, 16'd3); wr(5'd11, 16'd0); wr(5'd9, 16'h7);
    wr(5'd2, 16'd7);  wr(5'd3, 16'd0);  wr(5'd1, 16'h7);
    n0 = 0; n1 = 0; prev_ch = ch_irq;
    for (int k = 0; k < 72; k++) begin
      wr((k % 2) != 0 ? 5'd8 : 5'd0, 16'h0);
      if (k >= 8) begin
        if (ch_irq[0] && !prev_ch[0]) n0++;
        if (ch_irq[1] && !prev_ch[1]) n1++;
      end
      prev_ch = ch_irq;
    end
    check("indep_ch0", 32'(n0), 32'd8);
    check("indep_ch1", 32'(n1), 32'd16);
    rd(5'd24);
    check("oor_status", 32'(readdata), 32'h0);

    // Snapshot of a running counter, period 100, 10 cycles after START
    do_reset();
    wr(5'd2, 16'd100); wr(5'd3, 16'd0); wr(5'd1, 16'h4);
    repeat (10) rd(5'd0);
    wr(5'd4, 16'h0);
    rd(5'd4);
    check("snap_low", 32'(readdata), SNAP_ON ? 32'd90 : 32'd0);
    rd(5'd5);
    check("snap_high", 32'(readdata), 32'd0);

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int          ch  = $urandom_range(0, 3);
      int          off = $urandom_range(0, 7);
      logic [15:0] d;
      case (off)
        1:       d = 16'($urandom_range(0, 15));
        2:       d = 16'($urandom_range(0, 12));
        3:       d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
        default: d = 16'($urandom);
      endcase
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 5'(ch * 8 + off), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
